ad80305_rx_if_ddr_lvcmos_gen: RTL

- Transmitter end of the AD80305 RX LVCMOS DDR port. Emulates the RF chip's RX output so the FPGA-side DDR receiver can run in loopback and bench use without silicon.
- Buffers I/Q sample pairs arriving in the 125 MHz fabric domain and serialises them as I on the rising edge and Q on the falling edge of a generated 31.25 MHz clock.
- Drives a generated clock, frame and 12-bit data bus.

---
 rtl/ad80305_if_pkg.sv | 24 ++
 rtl/ad80305_iq_sync_fifo.sv | 62 ++++++
 rtl/ad80305_rx_if_ddr_lvcmos_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ad80305_if_pkg.sv
// Shared phase constants, FSM encoding and defaults for the AD80305 RX DDR emulator.
// One output pair spans four fabric cycles: ph3/ph0 carry I, ph1/ph2 carry Q.
package ad80305_if_pkg;

    localparam int DEF_DATA_W = 12;

    localparam logic [1:0] PH_I_LAUNCH = 2'd3;
    localparam logic [1:0] PH_CLK_RISE = 2'd0;
    localparam logic [1:0] PH_Q_LAUNCH = 2'd1;
    localparam logic [1:0] PH_CLK_FALL = 2'd2;
    localparam logic [1:0] PH_POP      = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Generated clock is high for the two phases following the rise.
    function automatic logic rx_clk_level(input logic [1:0] ph);
        return !((ph == PH_CLK_FALL) || (ph == PH_I_LAUNCH));
    endfunction

endpackage

// File: rtl/ad80305_iq_sync_fifo.sv
// Single-clock {I,Q} FIFO with registered occupancy; head word is read combinationally.
// Latency: push visible in o_level one cycle later. Backpressure: pushes ignored while full.
module ad80305_iq_sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dat,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dat   = r_mem[r_rd];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= i_dat;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_rd) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ad80305_rx_if_ddr_lvcmos_gen.sv
// AD80305 RX LVCMOS DDR source: replays buffered I/Q as I on o_rx_clk rise, Q on fall, one pair per 4 cycles.
// Latency: pop to bus 1 cycle (I) / 3 cycles (Q). Backpressure: o_iq_ready low while the FIFO is full.
// Option AD80305_RX_GEN_TEST_PATTERN_EN adds i_test_mode: counter pattern replaces FIFO data.
module ad80305_rx_if_ddr_lvcmos_gen
    import ad80305_if_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                          i_fpga_clk,
    input  logic                          i_fpga_rst,
    input  logic                          i_en,
`ifdef AD80305_RX_GEN_TEST_PATTERN_EN
    input  logic                          i_test_mode,
`endif
    input  logic                          i_iq_valid,
    output logic                          o_iq_ready,
    input  logic [DATA_W-1:0]             i_idata,
    input  logic [DATA_W-1:0]             i_qdata,
    output logic                          o_rx_clk,
    output logic                          o_rx_frame,
    output logic [DATA_W-1:0]             o_rx_data,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

    state_t              r_state;
    logic [1:0]          r_ph;
    logic [DATA_W-1:0]   r_q;

    logic [1:0]          w_ph_nxt;
    logic                w_push;
    logic                w_pop;
    logic                w_slot;
    logic                w_test;
    logic                w_empty;
    logic                w_full;
    logic [LVL_W-1:0]    w_level;
    logic [2*DATA_W-1:0] w_fifo_dat;
    logic [DATA_W-1:0]   w_pat;
    logic [DATA_W-1:0]   w_sel_i;
    logic [DATA_W-1:0]   w_sel_q;

    assign o_iq_ready   = !w_full;
    assign o_fifo_level = w_level;
    assign w_push       = i_iq_valid && !w_full;

    ad80305_iq_sync_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_fpga_clk),
        .i_rst_n (i_fpga_rst),
        .i_push  (w_push),
        .i_dat   ({i_idata, i_qdata}),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef AD80305_RX_GEN_TEST_PATTERN_EN
    logic [DATA_W-1:0] r_pat;

    assign w_test = i_test_mode;
    assign w_pat  = r_pat;

    always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
        if (!i_fpga_rst) begin
            r_pat <= '0;
        end else if (w_slot && i_test_mode) begin
            r_pat <= r_pat + 1'b1;
        end
    end
`else
    assign w_test = 1'b0;
    assign w_pat  = '0;
`endif

    assign w_ph_nxt = (r_ph == PH_I_LAUNCH) ? PH_CLK_RISE : r_ph + 2'd1;

    // A pair slot opens on ph2: every RUN symbol, or the PRIME symbol that finds enough data.
    assign w_slot = i_en && (r_ph == PH_POP) &&
                    ((r_state == RUN) || ((r_state == PRIME) && (w_level >= PRIME_LVL)));
    assign w_pop  = w_slot && !w_test && !w_empty;

    assign w_sel_i = w_test ? w_pat  : (w_empty ? '0 : w_fifo_dat[2*DATA_W-1:DATA_W]);
    assign w_sel_q = w_test ? ~w_pat : (w_empty ? '0 : w_fifo_dat[DATA_W-1:0]);

    always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
        if (!i_fpga_rst) begin
            r_state     <= IDLE;
            r_ph        <= PH_I_LAUNCH;
            r_q         <= '0;
            o_rx_clk    <= 1'b0;
            o_rx_frame  <= 1'b0;
            o_rx_data   <= '0;
            o_underflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ph       <= PH_I_LAUNCH;
                    o_rx_clk   <= 1'b0;
                    o_rx_frame <= 1'b0;
                    o_rx_data  <= '0;
                    if (i_en) begin
                        r_state <= PRIME;
                    end
                end

                PRIME: begin
                    if (!i_en) begin
                        r_state  <= IDLE;
                        r_ph     <= PH_I_LAUNCH;
                        o_rx_clk <= 1'b0;
                    end else begin
                        r_ph     <= w_ph_nxt;
                        o_rx_clk <= rx_clk_level(w_ph_nxt);
                        if (w_slot) begin
                            r_state    <= RUN;
                            o_rx_data  <= w_sel_i;
                            r_q        <= w_sel_q;
                            o_rx_frame <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    // Disable is only honoured once the in-flight pair has finished its Q half.
                    if ((r_ph == PH_POP) && !i_en) begin
                        r_state    <= IDLE;
                        r_ph       <= PH_I_LAUNCH;
                        o_rx_clk   <= 1'b0;
                        o_rx_frame <= 1'b0;
                        o_rx_data  <= '0;
                    end else begin
                        r_ph     <= w_ph_nxt;
                        o_rx_clk <= rx_clk_level(w_ph_nxt);
                        if (w_slot) begin
                            o_rx_data  <= w_sel_i;
                            r_q        <= w_sel_q;
                            o_rx_frame <= 1'b1;
                            if (w_empty && !w_test) begin
                                o_underflow <= 1'b1;
                            end
                        end else if (w_ph_nxt == PH_Q_LAUNCH) begin
                            o_rx_data  <= r_q;
                            o_rx_frame <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
